// File: rtl/csr_sparse_conv3x3_pkg.sv
// Shared definitions for the sparse CNN blocks: kernel geometry, FSM
// state encoding, output-size helper and the tap -> (ky,kx) lookup.
package sparse_cnn_pkg;

  localparam int KERNEL_DIM  = 3;
  localparam int KERNEL_TAPS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Tap t = ky*3+kx occupies bits [t*2 +: 2] of each table.
  localparam logic [2*KERNEL_TAPS-1:0] TAP_KY = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [2*KERNEL_TAPS-1:0] TAP_KX = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  // Valid-mode convolution output side length.
  function automatic int out_dim(input int row_num);
    return row_num - KERNEL_DIM + 1;
  endfunction

  function automatic logic [1:0] tap_ky(input logic [3:0] t);
    return TAP_KY[t*2 +: 2];
  endfunction

  function automatic logic [1:0] tap_kx(input logic [3:0] t);
    return TAP_KX[t*2 +: 2];
  endfunction

endpackage

// File: rtl/csr_sparse_conv3x3_tap_target.sv
// csr_tap_target: for one (entry, tap) pair, works out which output
// accumulator the product lands in, whether that target exists, and the
// sign-extended product. Purely combinational.
module csr_tap_target
  import sparse_cnn_pkg::*;
#(
  parameter int dataRowNum = 28,
  parameter int wordLength = 8,
  parameter int accLength  = 20,
  parameter int IDX_W      = 10
) (
  input  logic [wordLength-1:0] r_i,
  input  logic [wordLength-1:0] c_i,
  input  logic [3:0]            t_i,
  input  logic [wordLength-1:0] value_i,
  input  logic [wordLength-1:0] weight_i,
  output logic [IDX_W-1:0]      tgt_o,
  output logic                  in_range_o,
  output logic [accLength-1:0]  prod_o
);

  localparam int OUT_DIM = out_dim(dataRowNum);

  logic [wordLength-1:0]     ky, kx, ri, ci;
  logic signed [2*wordLength-1:0] prod;
  int                        idx;

  assign ky = wordLength'(tap_ky(t_i));
  assign kx = wordLength'(tap_kx(t_i));
  assign ri = r_i - ky;
  assign ci = c_i - kx;

  // Underflow is caught by the >= tests; r/c beyond the frame fall out via
  // the upper bound since r-ky >= dataRowNum-2 = OUT_DIM.
  assign in_range_o = (r_i >= ky) && (c_i >= kx) &&
                      (int'(ri) < OUT_DIM) && (int'(ci) < OUT_DIM);

  assign idx   = int'(ri) * OUT_DIM + int'(ci);
  assign tgt_o = IDX_W'(idx);

  assign prod   = $signed(value_i) * $signed(weight_i);
  assign prod_o = accLength'(prod);

endmodule

// File: rtl/csr_sparse_conv3x3.sv
// csr_sparse_conv3x3: scatters each CSR non-zero entry through the 3x3
// kernel into an output accumulator map, one (entry, tap) pair per cycle.
// Optional build macro CSR_SPARSE_CONV_RELU_EN clamps negative output
// words to zero on the output only.
module csr_sparse_conv3x3
  import sparse_cnn_pkg::*;
#(
  parameter int dataRowNum       = 28,
  parameter int wordLength       = 8,
  parameter int doublewordLength = 16,
  parameter int accLength        = 20
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  input  logic [doublewordLength-1:0]                      valid_num,
  input  logic [dataRowNum*dataRowNum*wordLength-1:0]      data_in,
  input  logic [dataRowNum*dataRowNum*wordLength-1:0]      cols,
  input  logic [dataRowNum*dataRowNum*wordLength-1:0]      rows,
  input  logic [KERNEL_TAPS*wordLength-1:0]                weights,
  output logic                                             busy,
  output logic                                             out_valid,
  output logic [out_dim(dataRowNum)*out_dim(dataRowNum)*accLength-1:0] data_out
);

  localparam int OUT_DIM = out_dim(dataRowNum);
  localparam int OUT_N   = OUT_DIM * OUT_DIM;
  localparam int IN_N    = dataRowNum * dataRowNum;
  localparam int E_W     = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int IDX_W   = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  state_e                           state_q;
  logic [E_W-1:0]                   e_q, n_last_q;
  logic [3:0]                       t_q;
  logic                             out_valid_q;
  logic [IN_N*wordLength-1:0]       data_q, cols_q, rows_q;
  logic [KERNEL_TAPS*wordLength-1:0] w_q;
  logic [OUT_N-1:0][accLength-1:0]  acc_q;

  logic                             accept;
  logic [doublewordLength-1:0]      n_eff;
  logic [IDX_W-1:0]                 tgt;
  logic                             in_range;
  logic [accLength-1:0]             prod;

  assign accept = (state_q == IDLE) && in_valid;
  // Counts beyond the frame size cannot be real entries; clamp them.
  assign n_eff  = (valid_num > doublewordLength'(IN_N)) ? doublewordLength'(IN_N) : valid_num;

  csr_tap_target #(
    .dataRowNum(dataRowNum),
    .wordLength(wordLength),
    .accLength (accLength),
    .IDX_W     (IDX_W)
  ) u_tap (
    .r_i       (rows_q[e_q*wordLength +: wordLength]),
    .c_i       (cols_q[e_q*wordLength +: wordLength]),
    .t_i       (t_q),
    .value_i   (data_q[e_q*wordLength +: wordLength]),
    .weight_i  (w_q[t_q*wordLength +: wordLength]),
    .tgt_o     (tgt),
    .in_range_o(in_range),
    .prod_o    (prod)
  );

  // Control FSM: tap counter is the inner loop, entry counter the outer.
  // out_valid is the registered image of the DONE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      e_q         <= '0;
      t_q         <= '0;
      n_last_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            e_q      <= '0;
            t_q      <= '0;
            n_last_q <= E_W'(n_eff - 1'b1);
            state_q  <= (n_eff != '0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (t_q == 4'(KERNEL_TAPS - 1)) begin
            t_q <= '0;
            if (e_q == n_last_q) state_q <= DONE;
            else                 e_q     <= e_q + 1'b1;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame capture so upstream is free to move on after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= data_in;
      cols_q <= cols;
      rows_q <= rows;
      w_q    <= weights;
    end
  end

  // Accumulator array: cleared on reset and on every new frame, then one
  // scatter-add per SCAN cycle; out-of-range targets are dropped.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      acc_q <= '0;
    end else if (state_q == SCAN && in_range) begin
      acc_q[tgt] <= acc_q[tgt] + prod;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;

  // Output map straight off the accumulators, optionally rectified.
  for (genvar k = 0; k < OUT_N; k++) begin : g_out
`ifdef CSR_SPARSE_CONV_RELU_EN
    assign data_out[k*accLength +: accLength] = acc_q[k][accLength-1] ? '0 : acc_q[k];
`else
    assign data_out[k*accLength +: accLength] = acc_q[k];
`endif
  end

endmodule

// File: tb/tb_csr_sparse_conv3x3.sv
// Directed bench for csr_sparse_conv3x3: a dense reference convolution
// produces expected maps and latencies into a scoreboard at capture time;
// they are popped and compared when out_valid appears.
module tb_csr_sparse_conv3x3;

  localparam int DRN = 28;
  localparam int WL  = 8;
  localparam int DWL = 16;
  localparam int AL  = 20;
  localparam int OD  = DRN - 2;
  localparam int ON  = OD * OD;
  localparam int IN  = DRN * DRN;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [DWL-1:0]      valid_num;
  logic [IN*WL-1:0]    data_in, cols, rows;
  logic [9*WL-1:0]     weights;
  logic                busy, out_valid;
  logic [ON*AL-1:0]    data_out;

  csr_sparse_conv3x3 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .valid_num(valid_num),
    .data_in  (data_in),
    .cols     (cols),
    .rows     (rows),
    .weights  (weights),
    .busy     (busy),
    .out_valid(out_valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int fails = 0;
  int ent_v[$], ent_r[$], ent_c[$];
  int w[9];
  logic [ON*AL-1:0] exp_q[$];
  int               lat_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_map(input string tag, input logic [ON*AL-1:0] act, input logic [ON*AL-1:0] exp);
    int k;
    k = 0;
    for (int i = 0; i < ON; i++)
      if (act[i*AL +: AL] !== exp[i*AL +: AL]) begin k = i; break; end
    vecs++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: word %0d got %0h expected %0h", tag, k, act[k*AL +: AL], exp[k*AL +: AL]);
    end
  endtask

  // Dense reference: out[i][j] = sum over taps of in[i+ky][j+kx]*w[ky*3+kx].
  function automatic logic [ON*AL-1:0] model();
    logic [ON*AL-1:0] m;
    int din[DRN][DRN];
    int s;
    logic [31:0] sv;
    logic [AL-1:0] wd;
    for (int r = 0; r < DRN; r++)
      for (int c = 0; c < DRN; c++) din[r][c] = 0;
    for (int e = 0; e < ent_v.size(); e++)
      if (ent_r[e] < DRN && ent_c[e] < DRN) din[ent_r[e]][ent_c[e]] += ent_v[e];
    m = '0;
    for (int i = 0; i < OD; i++)
      for (int j = 0; j < OD; j++) begin
        s = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) s += din[i+ky][j+kx] * w[ky*3+kx];
        sv = s;
        wd = sv[AL-1:0];
`ifdef CSR_SPARSE_CONV_RELU_EN
        if (wd[AL-1]) wd = '0;
`endif
        m[(i*OD+j)*AL +: AL] = wd;
      end
    return m;
  endfunction

  task automatic clr();
    ent_v.delete(); ent_r.delete(); ent_c.delete();
    for (int t = 0; t < 9; t++) w[t] = 0;
  endtask

  task automatic add(input int v, input int r, input int c);
    ent_v.push_back(v); ent_r.push_back(r); ent_c.push_back(c);
  endtask

  task automatic drive_frame(input int nv);
    logic [31:0] tmp;
    data_in = '0; cols = '0; rows = '0; weights = '0;
    for (int e = 0; e < ent_v.size() && e < IN; e++) begin
      tmp = ent_v[e]; data_in[e*WL +: WL] = tmp[WL-1:0];
      tmp = ent_r[e]; rows[e*WL +: WL]    = tmp[WL-1:0];
      tmp = ent_c[e]; cols[e*WL +: WL]    = tmp[WL-1:0];
    end
    for (int t = 0; t < 9; t++) begin
      tmp = w[t]; weights[t*WL +: WL] = tmp[WL-1:0];
    end
    valid_num = DWL'(nv);
  endtask

  // Called at a negedge; drives one frame, follows it to out_valid, checks.
  task automatic run_frame(input string tag, input int nv, input bit hold);
    int neff, lat, busy_cnt, exp_lat;
    logic [ON*AL-1:0] expm;
    neff = (nv > IN) ? IN : nv;
    drive_frame(nv);
    in_valid = 1'b1;
    exp_q.push_back(model());
    lat_q.push_back(9*neff + 1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    data_in = ~data_in; rows = ~rows; cols = ~cols; weights = ~weights;
    lat = 0; busy_cnt = 0;
    while (!out_valid && lat < 8000) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (hold) in_valid = 1'b0;
    exp_lat = lat_q.pop_front();
    expm    = exp_q.pop_front();
    if (!out_valid) begin
      check({tag, " timeout"}, 64'(lat), 64'(exp_lat));
    end else begin
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check({tag, " busy at valid"}, 64'(busy), 64'd0);
      check_map({tag, " map"}, data_out, expm);
      @(negedge clk);
      check({tag, " pulse width"}, 64'(out_valid), 64'd0);
      check_map({tag, " map hold"}, data_out, expm);
    end
  endtask

  task automatic frame_single();
    clr();
    add(5, 10, 10);
    for (int t = 0; t < 9; t++) w[t] = 1;
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0;
    clr();
    drive_frame(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check_map("reset map", data_out, '0);

    frame_single();
    run_frame("single", 1, 1'b0);

    clr();
    run_frame("empty", 0, 1'b0);

    clr();
    add(3, 0, 0);
    for (int t = 0; t < 9; t++) w[t] = 1;
    w[0] = 2;
    run_frame("corner00", 1, 1'b0);

    clr();
    add(3, 27, 27);
    for (int t = 0; t < 9; t++) w[t] = 1;
    w[8] = 4;
    run_frame("corner2727", 1, 1'b0);

    clr();
    add(4, 5, 5);
    w[4] = -3;
    run_frame("sign", 1, 1'b0);

    clr();
    add(2, 3, 3);
    add(7, 3, 4);
    for (int t = 0; t < 9; t++) w[t] = 1;
    run_frame("multi hold", 2, 1'b1);

    // Abort a frame in its fourth SCAN cycle.
    frame_single();
    drive_frame(1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort no pulse", 64'(seen), 64'd0);
    check_map("abort map", data_out, '0);

    frame_single();
    run_frame("after abort", 1, 1'b0);

    // Random sparse frame including one entry outside the frame.
    clr();
    for (int e = 0; e < 20; e++)
      add(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, DRN-1)), int'($urandom_range(0, DRN-1)));
    add(100, 40, 3);
    for (int t = 0; t < 9; t++) w[t] = int'($urandom_range(0, 255)) - 128;
    run_frame("random", 21, 1'b0);

    // Fully dense frame with an oversized count that must clamp to 784.
    clr();
    for (int e = 0; e < IN; e++) add(int'($urandom_range(0, 255)) - 128, e / DRN, e % DRN);
    for (int t = 0; t < 9; t++) w[t] = int'($urandom_range(0, 255)) - 128;
    run_frame("dense clamp", 16'hFFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
